// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised register file.
package rf_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  localparam int RF_WIDTH  = 32;
  localparam int RF_DEPTH  = 32;
  localparam int RF_NUM_RD = 2;

  // Address width for a given depth; never less than one bit.
  function automatic int rf_addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks the array one entry per cycle writing zero,
// blocks normal writes while running and flags any write it discards.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = rf_addr_width(RF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  input  logic          rd_we,
  output logic          clr_busy,
  output logic          wr_drop,
  output logic          clr_we,
  output logic          wr_block,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;

  // State, counter and the registered dropped-write pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wr_drop <= (state == RF_CLEAR) && rd_we;
    end
  end

  // Next state: start on request, leave after clearing the last entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nx = RF_CLEAR;
          cnt_nx   = '0;
        end
      end
      RF_CLEAR: begin
        if (cnt == LAST) begin
          state_nx = RF_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = RF_IDLE;
    endcase
  end

  assign clr_busy = (state == RF_CLEAR);
  assign clr_we   = clr_busy;
  assign wr_block = clr_busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: NUM_RD combinational read ports, one
// byte-enabled synchronous write port, optional hardwired-zero entry 0
// and a hardware clear sequencer.
// Optional macro RF_FORWARD_EN: same-cycle write-to-read forwarding.
module register_file_param
  import rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = RF_NUM_RD,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_addr_width(DEPTH),
  localparam int NB       = WIDTH / 8
) (
  input  logic                 reloj_cucu,
  input  logic                 reseteate,
  input  logic                 rd_we,
  input  logic [AW-1:0]        rd_addr,
  input  logic [WIDTH-1:0]     rd_w_data,
  input  logic [NB-1:0]        rd_be,
  input  logic [NUM_RD*AW-1:0] r_addr,
  output logic [NUM_RD*WIDTH-1:0] r_data,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 wr_drop
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_we;
  logic             wr_block;
  logic [AW-1:0]    clr_addr;
  logic             wr_ok;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr (
    .clk      (reloj_cucu),
    .rst_n    (reseteate),
    .clr_req  (clr_req),
    .rd_we    (rd_we),
    .clr_busy (clr_busy),
    .wr_drop  (wr_drop),
    .clr_we   (clr_we),
    .wr_block (wr_block),
    .clr_addr (clr_addr)
  );

  // Write qualification and byte merge of new data over the stored word.
  always_comb begin
    wr_ok = rd_we && !wr_block && (int'(rd_addr) < DEPTH) &&
            !((ZERO_REG != 0) && (rd_addr == '0));
    wr_old = '0;
    if (int'(rd_addr) < DEPTH) wr_old = mem[rd_addr];
    wr_merged = wr_old;
    for (int unsigned k = 0; k < NB; k++) begin
      if (rd_be[k]) wr_merged[8*k +: 8] = rd_w_data[8*k +: 8];
    end
  end

  // Storage: async clear on reset, sequencer clear has priority over writes.
  always_ff @(posedge reloj_cucu or negedge reseteate) begin
    if (!reseteate) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[rd_addr] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    // Read mux: out-of-range and hardwired-zero addresses return zero.
    always_comb begin
      ra = r_addr[p*AW +: AW];
      rv = '0;
      if ((int'(ra) < DEPTH) && !((ZERO_REG != 0) && (ra == '0))) rv = mem[ra];
`ifdef RF_FORWARD_EN
      if (wr_ok && (ra == rd_addr)) rv = wr_merged;
`endif
    end

    assign r_data[p*WIDTH +: WIDTH] = rv;
  end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param (default parameters).
module tb_register_file_param;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 32;
  localparam int NUM_RD   = 2;
  localparam int ZERO_REG = 1;
  localparam int AW       = 5;
  localparam int NB       = 4;

  logic                    reloj_cucu = 1'b0;
  logic                    reseteate  = 1'b1;
  logic                    rd_we;
  logic [AW-1:0]           rd_addr;
  logic [WIDTH-1:0]        rd_w_data;
  logic [NB-1:0]           rd_be;
  logic [NUM_RD*AW-1:0]    r_addr;
  logic [NUM_RD*WIDTH-1:0] r_data;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    wr_drop;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  register_file_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .reloj_cucu (reloj_cucu),
    .reseteate  (reseteate),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr),
    .rd_w_data  (rd_w_data),
    .rd_be      (rd_be),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .wr_drop    (wr_drop)
  );

  always #5 reloj_cucu = ~reloj_cucu;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_left = 0;   // clear cycles still to run; 0 = idle
  logic             m_drop = 1'b0;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_w,
                                             input logic [WIDTH-1:0] new_w,
                                             input logic [NB-1:0] be);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic wr_target_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == 0));
  endfunction

  always @(posedge reloj_cucu or negedge reseteate) begin
    if (!reseteate) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_left <= 0;
      m_drop <= 1'b0;
    end else begin
      m_drop <= (m_left > 0) && rd_we;
      if (m_left > 0) begin
        m_mem[DEPTH - m_left] <= '0;
        m_left <= m_left - 1;
      end else begin
        if (rd_we && wr_target_ok(rd_addr))
          m_mem[rd_addr] <= merge(m_mem[rd_addr], rd_w_data, rd_be);
        if (clr_req) m_left <= DEPTH;
      end
    end
  end

  function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
    logic [WIDTH-1:0] r;
    if (!wr_target_ok(a)) return '0;
    r = m_mem[a];
`ifdef RF_FORWARD_EN
    if (m_left == 0 && rd_we && a == rd_addr) r = merge(r, rd_w_data, rd_be);
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge reloj_cucu) begin
    if (chk_en) begin
      chk("cyc_clr_busy", {31'b0, clr_busy}, {31'b0, m_left > 0});
      chk("cyc_wr_drop", {31'b0, wr_drop}, {31'b0, m_drop});
      for (int p = 0; p < NUM_RD; p++)
        chk($sformatf("cyc_rdata%0d", p), r_data[p*WIDTH +: WIDTH],
            exp_rd(r_addr[p*AW +: AW]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge reloj_cucu);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                    input logic [NB-1:0] be);
    rd_we = 1'b1; rd_addr = a; rd_w_data = d; rd_be = be;
    tick();
    rd_we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    r_addr = {a1, a0};
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  busy;
    int  drops;
    bit  done;

    rd_we = 1'b0; rd_addr = '0; rd_w_data = '0; rd_be = '0;
    r_addr = '0; clr_req = 1'b0;
    reseteate = 1'b0;
    #1 chk_en = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_busy", {31'b0, clr_busy}, 32'd0);
    chk("rst_drop", {31'b0, wr_drop}, 32'd0);
    rd(5, 31);
    chk("rst_rd0", r_data[31:0], 32'd0);
    chk("rst_rd1", r_data[63:32], 32'd0);
    reseteate = 1'b1;
    tick();

    // Basic write / read
    wr(5, 32'hDEADBEEF, 4'hF);
    rd(5, 0);
    chk("a5_full", r_data[31:0], 32'hDEADBEEF);
    chk("a0_port1", r_data[63:32], 32'd0);

    // Byte enables
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'b0101);
    rd(7, 7);
    chk("a7_bytes", r_data[31:0], 32'h11BB33DD);
    chk("a7_bytes_p1", r_data[63:32], 32'h11BB33DD);

    // Hardwired zero and top entry
    wr(0, 32'hFFFFFFFF, 4'hF);
    rd(0, 5);
    chk("a0_zero", r_data[31:0], 32'd0);
    chk("a5_hold", r_data[63:32], 32'hDEADBEEF);
    wr(31, 32'd31, 4'hF);
    rd(31, 0);
    chk("a31", r_data[31:0], 32'd31);

    // Zero byte enable is a no-op
    wr(5, 32'h0, 4'h0);
    rd(5, 7);
    chk("be0_noop", r_data[31:0], 32'hDEADBEEF);

    // Fill, then run the clear sequence with a dropped write in cycle 4
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), 32'(i), 4'hF);
    rd(3, 30);
    chk("fill_a3", r_data[31:0], 32'd3);
    chk("fill_a30", r_data[63:32], 32'd30);

    clr_req = 1'b1;
    busy = 0; drops = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      clr_req = 1'b0;
      rd_we   = 1'b0;
      if (clr_busy) busy++; else done = 1'b1;
      if (wr_drop) drops++;
      if (busy == 4 && clr_busy) begin
        rd_we = 1'b1; rd_addr = 3; rd_w_data = 32'h77; rd_be = 4'hF;
      end
    end
    rd_we = 1'b0;
    chk("clr_done", {31'b0, done}, 32'd1);
    chk("clr_cycles", 32'(busy), 32'd32);
    chk("drop_pulses", 32'(drops), 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a), AW'(DEPTH - 1 - a));
      chk($sformatf("cleared_a%0d", a), r_data[31:0], 32'd0);
    end

    // Reset during the clear sequence
    wr(20, 32'h55, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    chk("mid_busy", {31'b0, clr_busy}, 32'd1);
    reseteate = 1'b0;
    #1;
    chk("abort_busy", {31'b0, clr_busy}, 32'd0);
    rd(20, 31);
    chk("abort_a20", r_data[31:0], 32'd0);
    tick();
    reseteate = 1'b1;
    wr(12, 32'hCAFEF00D, 4'hF);
    rd(12, 20);
    chk("post_rst_wr", r_data[31:0], 32'hCAFEF00D);
    chk("post_rst_a20", r_data[63:32], 32'd0);

    // Same-cycle read of an entry being written
    r_addr = {AW'(0), AW'(9)};
    rd_we = 1'b1; rd_addr = 9; rd_w_data = 32'h42; rd_be = 4'hF;
    #1;
`ifdef RF_FORWARD_EN
    chk("fwd_same_cycle", r_data[31:0], 32'h42);
`else
    chk("fwd_same_cycle", r_data[31:0], 32'h0);
`endif
    tick();
    rd_we = 1'b0;
    #1;
    chk("fwd_next_cycle", r_data[31:0], 32'h42);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
